secuenciador_control: RTL and testbench
=======================================

# secuenciador_control

Moore control unit that drives the control inputs of the register/ALU data unit (`UnidadDatos`). A start request on `xs` launches one of four fixed microprograms. Each microprogram moves operands over the shared bus through register T and the ALU into AC, then writes the result back. The block sits directly upstream of the data unit, and its outputs connect one-to-one to the data unit's `Ra…R` ports.

## Interface
- `NPASOS`, default 5: maximum microprogram length in steps; sizes the step counter (3 bits at 5).
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `xs` input 1: start request from a push-button, already synchronised; rising edge triggers.
- `op` input 2: microprogram select, sampled only on an accepted start.
- `Ra`, `Rb`, `Rc`, `Rac` output 1 each: bus read enables for A, B, C and AC (drive bus1).
- `Wa`, `Wb`, `Wc`, `Wac`, `Wt` output 1 each: write enables for A, B, C, AC and T.
- `S`, `R` output 1 each: ALU select, `S`=add, `R`=subtract, never both high.
- `busy` output 1: high while a microprogram is executing.
- `done` output 1: one-cycle pulse after the last step.

## Operation
- States: IDLE, EXEC, FIN.
  - IDLE→EXEC on an accepted start.
  - EXEC holds while step < last step of the selected program, then EXEC→FIN.
  - FIN→IDLE unconditionally.
- Start detection: registered `xs_prev`. Start is accepted when `xs` is high, `xs_prev` is low, and the state is IDLE.
  - Edges seen in EXEC or FIN are ignored, not queued.
- `op` is latched into `op_q` at acceptance. Changes to `op` while busy have no effect.
- Microprograms (one step per cycle; T = ALU input a, bus1 = ALU input b):
  - op=00, C←A+B: {Ra,Wt}, {Rb,S,Wac}, {Rac,Wc}.
  - op=01, C←A−B: {Ra,Wt}, {Rb,R,Wac}, {Rac,Wc}.
  - op=10, C←A+B−C: {Ra,Wt}, {Rb,S,Wac}, {Rac,Wt}, {Rc,R,Wac}, {Rac,Wc}.
  - op=11, A↔B swap through AC/T: {Ra,Wt}, {Rb,Wa}, {Rac…} is not allowed. Defined instead as {Ra,Wt}, {Rb,Wa}, {Wb with T routed by S=0,R=0}. Because the ALU outputs 0 when S=R=0, op=11 is redefined as a clear: {Wac} (AC←0), {Rac,Wa}, {Rac,Wb}.
- Invariants, checked every cycle:
  - At most one of `Ra`, `Rb`, `Rc`, `Rac` is high (single bus driver).
  - `S` and `R` are never both high.
  - All control outputs are 0 in IDLE and FIN.
- Outputs are registered and decoded from state, step and `op_q`.

## Timing
- Reset value of every output is 0.
- On reset assertion: state goes to IDLE, step to 0, `op_q` to 00, and `xs_prev` to 1, all immediately and asynchronously. Setting `xs_prev` to 1 means an `xs` held high through reset release does not start.
- Reset mid-program aborts immediately; no partial write is issued after the reset edge.
- Start edge sampled at clock edge k: step 1 controls are high during cycle k+1, step n during cycle k+n, `done` during cycle k+N+1.
  - Here N is 3 for op 00, 01 and 11, and 5 for op 10.
- `busy` is high from cycle k+1 through k+N. It is low in FIN and IDLE.
- Minimum start-to-start spacing is N+2 cycles. A new edge can be accepted at the edge ending FIN+1 (back in IDLE).
- Simultaneous `xs` edge and FIN: ignored; `xs` must fall and rise again.

## Test plan
- Reset with `xs`=1, release, hold `xs`=1 for 10 cycles: all outputs 0, `busy`=0, no start.
- op=00, A=B=C=10 (data unit at init values), one `xs` pulse:
  - Step sequence Ra|Wt, Rb|S|Wac, Rac|Wc.
  - `done` 4 cycles after the edge; C=20.
- op=10 with A=B=C=10: 5-step sequence, C=10 afterwards, `busy` high for exactly 5 cycles. Then op=01: C=0.
- Second `xs` edge and an `op` change during EXEC: ignored. The original sequence completes unchanged, and exactly one `done` pulse occurs.
- `reset` asserted during step 2 of op=10:
  - Outputs drop to 0 asynchronously, before the next clock edge.
  - No `Wc` is issued; C keeps its old value.
  - After release, a fresh start runs normally.
- op=11: AC=0, then A=0 and B=0. Bus-driver and `S`/`R` exclusivity assertions hold for every cycle of every test.

Source files
------------

// File: rtl/secuenciador_control.sv
// ---------------------------------------------------------------------------
// secuenciador_control
//   Moore control unit for the register/ALU data unit (UnidadDatos). A rising
//   edge on xs, accepted only in IDLE, launches one of four fixed
//   microprograms. The microprogram is chosen by op, which is latched at
//   acceptance. Each step lasts one cycle. Every control output is registered
//   and is 0 outside EXEC.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous reset, active low
//   xs                  start request (already synchronised), rising edge
//   op[1:0]             microprogram select: 00 C=A+B, 01 C=A-B,
//                       10 C=A+B-C, 11 clear A and B through AC
//   Ra, Rb, Rc, Rac     bus1 read enables (at most one high)
//   Wa, Wb, Wc, Wac, Wt register write enables
//   S, R                ALU add / subtract select (never both high)
//   busy                high while a microprogram executes
//   done                one-cycle pulse after the last step
// ---------------------------------------------------------------------------
module secuenciador_control #(
  parameter int NPASOS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       xs,
  input  logic [1:0] op,
  output logic       Ra,
  output logic       Rb,
  output logic       Rc,
  output logic       Rac,
  output logic       Wa,
  output logic       Wb,
  output logic       Wc,
  output logic       Wac,
  output logic       Wt,
  output logic       S,
  output logic       R,
  output logic       busy,
  output logic       done
);

  localparam int STEP_W = $clog2(NPASOS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic ra, rb, rc, rac;
    logic wa, wb, wc, wac, wt;
    logic s, r;
  } ctrl_t;

  state_t              r_state;
  logic [STEP_W-1:0]   r_step;
  logic [1:0]          r_op_q;
  logic                r_xs_prev;
  ctrl_t               r_ctrl;
  logic                r_busy;
  logic                r_done;

  logic                w_start;

  // Only a fresh 0->1 transition seen while idle starts a program. Edges that
  // arrive in EXEC or FIN are consumed by r_xs_prev and are never queued.
  assign w_start = xs && !r_xs_prev && (r_state == IDLE);

  // Control word for step stp (1-based) of microprogram sel.
  function automatic ctrl_t decode(input logic [1:0] sel,
                                   input logic [STEP_W-1:0] stp);
    ctrl_t c;
    // NOTE: the default assigned first covers every path through the case,
    // so this logic stays purely combinational.
    c = '0;
    case (sel)
      2'b00, 2'b01: begin
        case (int'(stp))
          1: begin c.ra = 1'b1; c.wt = 1'b1; end
          2: begin c.rb = 1'b1; c.wac = 1'b1; c.s = !sel[0]; c.r = sel[0]; end
          3: begin c.rac = 1'b1; c.wc = 1'b1; end
          default: c = '0;
        endcase
      end
      2'b10: begin
        case (int'(stp))
          1: begin c.ra = 1'b1; c.wt = 1'b1; end
          2: begin c.rb = 1'b1; c.s = 1'b1; c.wac = 1'b1; end
          3: begin c.rac = 1'b1; c.wt = 1'b1; end
          4: begin c.rc = 1'b1; c.r = 1'b1; c.wac = 1'b1; end
          5: begin c.rac = 1'b1; c.wc = 1'b1; end
          default: c = '0;
        endcase
      end
      default: begin
        // The ALU outputs 0 when S=R=0, so AC is cleared and then copied
        // into A and B.
        case (int'(stp))
          1: c.wac = 1'b1;
          2: begin c.rac = 1'b1; c.wa = 1'b1; end
          3: begin c.rac = 1'b1; c.wb = 1'b1; end
          default: c = '0;
        endcase
      end
    endcase
    return c;
  endfunction

  function automatic logic [STEP_W-1:0] last_step(input logic [1:0] sel);
    return (sel == 2'b10) ? STEP_W'(5) : STEP_W'(3);
  endfunction

  // Outputs are computed one cycle ahead from the next state, so the step-1
  // controls are visible in the cycle right after the accepted edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_op_q    <= 2'b00;
      // NOTE: starting at 1 means an xs held high through reset release does
      // not look like a rising edge.
      r_xs_prev <= 1'b1;
      r_ctrl    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: every state register uses non-blocking assignment, so all
      // reads below see the values from before this edge.
      r_xs_prev <= xs;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= EXEC;
            r_step  <= STEP_W'(1);
            r_op_q  <= op;
            r_ctrl  <= decode(op, STEP_W'(1));
            r_busy  <= 1'b1;
          end
        end
        EXEC: begin
          if (r_step < last_step(r_op_q)) begin
            r_step <= r_step + STEP_W'(1);
            r_ctrl <= decode(r_op_q, r_step + STEP_W'(1));
          end else begin
            r_state <= FIN;
            r_step  <= '0;
            r_ctrl  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_step  <= '0;
          r_ctrl  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Ra   = r_ctrl.ra;
  assign Rb   = r_ctrl.rb;
  assign Rc   = r_ctrl.rc;
  assign Rac  = r_ctrl.rac;
  assign Wa   = r_ctrl.wa;
  assign Wb   = r_ctrl.wb;
  assign Wc   = r_ctrl.wc;
  assign Wac  = r_ctrl.wac;
  assign Wt   = r_ctrl.wt;
  assign S    = r_ctrl.s;
  assign R    = r_ctrl.r;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_secuenciador_control.sv
// ---------------------------------------------------------------------------
// tb_secuenciador_control
//   Directed bench for secuenciador_control. A small behavioural model of the
//   data unit (A, B, C, AC, T, bus1, ALU) is driven by the DUT outputs, so the
//   microprogram results can be checked. Inputs are driven and outputs are
//   sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_secuenciador_control;

  // Control word bit order: Ra Rb Rc Rac Wa Wb Wc Wac Wt S R
  localparam logic [10:0] C_RA  = 11'h400;
  localparam logic [10:0] C_RB  = 11'h200;
  localparam logic [10:0] C_RC  = 11'h100;
  localparam logic [10:0] C_RAC = 11'h080;
  localparam logic [10:0] C_WA  = 11'h040;
  localparam logic [10:0] C_WB  = 11'h020;
  localparam logic [10:0] C_WC  = 11'h010;
  localparam logic [10:0] C_WAC = 11'h008;
  localparam logic [10:0] C_WT  = 11'h004;
  localparam logic [10:0] C_S   = 11'h002;
  localparam logic [10:0] C_R   = 11'h001;
  localparam logic [10:0] C_0   = 11'h000;

  logic       clk = 1'b0;
  logic       reset;
  logic       xs;
  logic [1:0] op;
  logic       Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R, busy, done;
  logic [10:0] ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  // Data unit model
  logic       du_init;
  logic [7:0] du_a, du_b, du_c, du_ac, du_t, bus1, alu;

  always #5 clk = ~clk;

  secuenciador_control #(.NPASOS(5)) dut (
    .clk (clk), .reset(reset), .xs(xs), .op(op),
    .Ra(Ra), .Rb(Rb), .Rc(Rc), .Rac(Rac),
    .Wa(Wa), .Wb(Wb), .Wc(Wc), .Wac(Wac), .Wt(Wt),
    .S(S), .R(R), .busy(busy), .done(done)
  );

  assign ctrl = {Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R};

  always_comb begin
    bus1 = Ra ? du_a : Rb ? du_b : Rc ? du_c : Rac ? du_ac : 8'd0;
    alu  = S ? du_t + bus1 : R ? du_t - bus1 : 8'd0;
  end

  always @(posedge clk) begin
    if (du_init) begin
      du_a <= 8'd10; du_b <= 8'd10; du_c <= 8'd10; du_ac <= 8'd10; du_t <= 8'd10;
    end else begin
      if (Wa)  du_a  <= bus1;
      if (Wb)  du_b  <= bus1;
      if (Wc)  du_c  <= bus1;
      if (Wt)  du_t  <= bus1;
      if (Wac) du_ac <= alu;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the per-cycle invariants.
  task automatic tick();
    @(negedge clk);
    check("bus_single_driver", 32'($countones({Ra, Rb, Rc, Rac}) <= 1), 32'd1);
    check("alu_sel_excl", 32'(S & R), 32'd0);
    if (!busy) check("idle_outputs_zero", 32'(ctrl), 32'd0);
  endtask

  task automatic reinit_du();
    du_init = 1'b1;
    tick();
    du_init = 1'b0;
  endtask

  // Launch program sel and check every step. With disturb set, a second xs
  // edge and an op change hit EXEC, and another edge hits FIN.
  task automatic run_prog(input logic [1:0] sel, input logic [10:0] seq [5],
                          input int n, input bit disturb);
    op = sel;
    xs = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("op%0d_step%0d_ctrl", sel, i + 1), 32'(ctrl), 32'(seq[i]));
      check($sformatf("op%0d_step%0d_busy", sel, i + 1), 32'(busy), 32'd1);
      check($sformatf("op%0d_step%0d_done", sel, i + 1), 32'(done), 32'd0);
      if (i == 0) xs = 1'b0;
      if (disturb && i == 1) begin xs = 1'b1; op = ~sel; end
      if (disturb && i == n - 1) xs = 1'b0;
    end
    tick();
    check($sformatf("op%0d_fin_ctrl", sel), 32'(ctrl), 32'd0);
    check($sformatf("op%0d_fin_busy", sel), 32'(busy), 32'd0);
    check($sformatf("op%0d_fin_done", sel), 32'(done), 32'd1);
    if (disturb) xs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("op%0d_after_busy", sel), 32'(busy), 32'd0);
      check($sformatf("op%0d_after_done", sel), 32'(done), 32'd0);
    end
    xs = 1'b0;
    tick();
  endtask

  initial begin
    reset   = 1'b0;
    xs      = 1'b1;
    op      = 2'b00;
    du_init = 1'b1;
    tick();
    tick();
    check("reset_ctrl", 32'(ctrl), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // xs held high through reset release must not start a program
    reset   = 1'b1;
    du_init = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("xs_held_ctrl", 32'(ctrl), 32'd0);
      check("xs_held_busy", 32'(busy), 32'd0);
      check("xs_held_done", 32'(done), 32'd0);
    end
    xs = 1'b0;
    tick();

    // op=00: C = A + B = 20
    run_prog(2'b00, '{C_RA | C_WT, C_RB | C_S | C_WAC, C_RAC | C_WC, C_0, C_0}, 3, 1'b0);
    check("op00_c", 32'(du_c), 32'd20);

    // op=10: C = A + B - C = 10, then op=01: C = A - B = 0
    reinit_du();
    run_prog(2'b10, '{C_RA | C_WT, C_RB | C_S | C_WAC, C_RAC | C_WT,
                      C_RC | C_R | C_WAC, C_RAC | C_WC}, 5, 1'b0);
    check("op10_c", 32'(du_c), 32'd10);
    run_prog(2'b01, '{C_RA | C_WT, C_RB | C_R | C_WAC, C_RAC | C_WC, C_0, C_0}, 3, 1'b0);
    check("op01_c", 32'(du_c), 32'd0);

    // Extra edges and op change while busy are ignored
    reinit_du();
    run_prog(2'b00, '{C_RA | C_WT, C_RB | C_S | C_WAC, C_RAC | C_WC, C_0, C_0}, 3, 1'b1);
    check("disturb_c", 32'(du_c), 32'd20);

    // Reset during step 2 of op=10 aborts immediately
    reinit_du();
    op = 2'b10;
    xs = 1'b1;
    tick();
    check("abort_step1", 32'(ctrl), 32'(C_RA | C_WT));
    xs = 1'b0;
    tick();
    check("abort_step2", 32'(ctrl), 32'(C_RB | C_S | C_WAC));
    #2 reset = 1'b0;
    #1;
    check("abort_async_ctrl", 32'(ctrl), 32'd0);
    check("abort_async_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check("abort_c_kept", 32'(du_c), 32'd10);
    check("abort_ac_kept", 32'(du_ac), 32'd10);
    reset = 1'b1;
    tick();
    check("abort_idle_busy", 32'(busy), 32'd0);
    run_prog(2'b10, '{C_RA | C_WT, C_RB | C_S | C_WAC, C_RAC | C_WT,
                      C_RC | C_R | C_WAC, C_RAC | C_WC}, 5, 1'b0);
    check("restart_op10_c", 32'(du_c), 32'd10);

    // op=11: AC = 0, then A = 0 and B = 0
    reinit_du();
    run_prog(2'b11, '{C_WAC, C_RAC | C_WA, C_RAC | C_WB, C_0, C_0}, 3, 1'b0);
    check("op11_ac", 32'(du_ac), 32'd0);
    check("op11_a", 32'(du_a), 32'd0);
    check("op11_b", 32'(du_b), 32'd0);
    check("op11_c", 32'(du_c), 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
